mem_arbiter: RTL and testbench

Arbitrates one shared single-port memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipelined core. It holds each accepted request stable on the memory port until the memory acknowledges, and returns a one-cycle completion strobe to the winning requester. The hazard unit stalls F or M on the `~ready` of the corresponding requester. A watchdog flags a memory that never acknowledges.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_watchdog.sv | 45 ++++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the instruction/data memory
// arbiter.
//   arb_state_t : arbiter FSM states (idle, fetch busy, data busy)
//   TIMEOUT_W   : width of the watchdog busy-cycle counter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IBUSY = 2'd1,
        ARB_DBUSY = 2'd2
    } arb_state_t;

    localparam int TIMEOUT_W = 8;

endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: busy-cycle counter with a sticky timeout flag.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-low reset
//   clear  in  zero the counter (takes priority over enable)
//   enable in  count one busy cycle
//   err    out sticky flag, set the cycle after the count reaches TIMEOUT;
//              only reset clears it
module arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic err
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT);

    logic [TIMEOUT_W-1:0] countReg;
    logic                 errReg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            countReg <= '0;
            errReg   <= 1'b0;
        end else begin
            if (clear) begin
                countReg <= '0;
            end else if (enable && (countReg != LIMIT)) begin
                // Saturate at the limit so a stuck memory never wraps the count
                countReg <= countReg + TIMEOUT_W'(1);
            end
            if (countReg == LIMIT) begin
                errReg <= 1'b1;
            end
        end
    end

    assign err = errReg;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch stage
// (instruction reads) and the memory stage (loads/stores). Data has priority;
// an accepted request is latched and held on the memory port until mready.
// Optional macro ARB_STARVE_GUARD_EN: after STARVE_LIMIT consecutive data
// grants made while a fetch waits, the next arbitration goes to the fetch.
// Ports:
//   clk, reset               clock; asynchronous active-low reset
//   ireq/iaddr               fetch read request
//   iready/irdata            fetch completion strobe and read data
//   dreq/dwe/daddr/dwdata    data request (dwe=1 is a store)
//   dready/drdata            data completion strobe and load data
//   mreq/mwe/maddr/mwdata    registered memory request
//   mrdata/mready            memory read data and single-cycle acknowledge
//   err                      sticky watchdog timeout flag
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ireq,
    input  logic [WIDTH-1:0] iaddr,
    output logic             iready,
    output logic [WIDTH-1:0] irdata,
    input  logic             dreq,
    input  logic             dwe,
    input  logic [WIDTH-1:0] daddr,
    input  logic [WIDTH-1:0] dwdata,
    output logic             dready,
    output logic [WIDTH-1:0] drdata,
    output logic             mreq,
    output logic             mwe,
    output logic [WIDTH-1:0] maddr,
    output logic [WIDTH-1:0] mwdata,
    input  logic [WIDTH-1:0] mrdata,
    input  logic             mready,
    output logic             err
);

    arb_state_t       stateReg;
    logic             mreqReg;
    logic             mweReg;
    logic [WIDTH-1:0] maddrReg;
    logic [WIDTH-1:0] mwdataReg;

    logic favorFetch;
    logic grantData;
    logic grantFetch;
    logic busy;

    // Arbitration terms are only acted on in ARB_IDLE
    always_comb begin
        grantData  = dreq & ~favorFetch;
        grantFetch = ireq & ~grantData;
    end

`ifdef ARB_STARVE_GUARD_EN
    // One extra bit so the count can hold STARVE_LIMIT itself
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 2);

    logic [STARVE_W-1:0] starveCntReg;

    assign favorFetch = ireq && (starveCntReg == STARVE_W'(STARVE_LIMIT));

    // At the limit a waiting fetch always wins, so the count cannot overrun
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starveCntReg <= '0;
        end else if (stateReg == ARB_IDLE) begin
            if (grantData && ireq) begin
                starveCntReg <= starveCntReg + STARVE_W'(1);
            end else if (grantFetch) begin
                starveCntReg <= '0;
            end
        end
    end
`else
    // Strict data priority; STARVE_LIMIT only matters in guard builds
    logic unusedStarveLimit;
    assign unusedStarveLimit = (STARVE_LIMIT != 0);
    assign favorFetch        = 1'b0;
`endif

    // Arbiter FSM with registered memory-port outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg  <= ARB_IDLE;
            mreqReg   <= 1'b0;
            mweReg    <= 1'b0;
            maddrReg  <= '0;
            mwdataReg <= '0;
        end else begin
            case (stateReg)
                ARB_IDLE: begin
                    if (grantData) begin
                        stateReg  <= ARB_DBUSY;
                        mreqReg   <= 1'b1;
                        mweReg    <= dwe;
                        maddrReg  <= daddr;
                        mwdataReg <= dwdata;
                    end else if (grantFetch) begin
                        stateReg <= ARB_IBUSY;
                        mreqReg  <= 1'b1;
                        mweReg   <= 1'b0;
                        maddrReg <= iaddr;
                    end
                end
                ARB_IBUSY, ARB_DBUSY: begin
                    // Latched request stays on the port; requester inputs ignored
                    if (mready) begin
                        stateReg <= ARB_IDLE;
                        mreqReg  <= 1'b0;
                        mweReg   <= 1'b0;
                    end
                end
                default: begin
                    stateReg <= ARB_IDLE;
                    mreqReg  <= 1'b0;
                    mweReg   <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (stateReg != ARB_IDLE);

    // Count busy cycles; clear while idle and on the acknowledge that returns
    // the FSM to idle
    arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) uWatchdog (
        .clk   (clk),
        .reset (reset),
        .clear (~busy | mready),
        .enable(busy),
        .err   (err)
    );

    // Completion strobes are combinational so the stage unstalls in the
    // acknowledge cycle; mready seen in ARB_IDLE produces nothing
    assign iready = mready & (stateReg == ARB_IBUSY);
    assign dready = mready & (stateReg == ARB_DBUSY);
    assign irdata = mrdata;
    assign drdata = mrdata;

    assign mreq   = mreqReg;
    assign mwe    = mweReg;
    assign maddr  = maddrReg;
    assign mwdata = mwdataReg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed test of mem_arbiter with a transaction scoreboard.
// Expected transactions are queued when a request is driven and checked when
// the memory port shows them and when the completion strobe fires.
module tb_mem_arbiter;

    localparam int W = 32;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         ireq;
    logic [W-1:0] iaddr;
    logic         iready;
    logic [W-1:0] irdata;
    logic         dreq;
    logic         dwe;
    logic [W-1:0] daddr;
    logic [W-1:0] dwdata;
    logic         dready;
    logic [W-1:0] drdata;
    logic         mreq;
    logic         mwe;
    logic [W-1:0] maddr;
    logic [W-1:0] mwdata;
    logic [W-1:0] mrdata;
    logic         mready;
    logic         err;

    typedef struct {
        bit           isData;
        bit           we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
    } txn_t;

    txn_t expQ[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .WIDTH(W),
        .STARVE_LIMIT(4),
        .TIMEOUT(255)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iaddr (iaddr),
        .iready(iready),
        .irdata(irdata),
        .dreq  (dreq),
        .dwe   (dwe),
        .daddr (daddr),
        .dwdata(dwdata),
        .dready(dready),
        .drdata(drdata),
        .mreq  (mreq),
        .mwe   (mwe),
        .maddr (maddr),
        .mwdata(mwdata),
        .mrdata(mrdata),
        .mready(mready),
        .err   (err)
    );

    // Memory model: read data is a fixed scramble of the address
    function automatic logic [W-1:0] memData(input logic [W-1:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign mrdata = memData(maddr);

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit isData, input bit we, input logic [W-1:0] a, input logic [W-1:0] wd);
        txn_t t;
        t.isData = isData;
        t.we     = we;
        t.addr   = a;
        t.wdata  = wd;
        expQ.push_back(t);
    endtask

    task automatic awaitGrant(input string tag, output int waited);
        waited = 0;
        while (!mreq && waited < 20) begin
            cycle();
            waited++;
        end
        check({tag, ".grant"}, W'(mreq), W'(1));
    endtask

    // Compare the memory port against the scoreboard head
    task automatic checkHead(input string tag);
        check({tag, ".sbNonEmpty"}, W'(expQ.size() != 0), W'(1));
        if (expQ.size() != 0) begin
            check({tag, ".maddr"}, maddr, expQ[0].addr);
            check({tag, ".mwe"}, W'(mwe), W'(expQ[0].we));
            if (expQ[0].we) begin
                check({tag, ".mwdata"}, mwdata, expQ[0].wdata);
            end
        end
        $display("txn %s: maddr=%0h mwe=%0b mwdata=%0h", tag, maddr, mwe, mwdata);
    endtask

    // Hold the busy state until busy cycle lat, acknowledge, check the
    // strobe and read data, then step into the idle cycle that follows
    task automatic complete(input string tag, input int lat);
        txn_t h;
        for (int i = 1; i < lat; i++) begin
            cycle();
            check({tag, ".mreqHeld"}, W'(mreq), W'(1));
            check({tag, ".noStrobe"}, W'({iready, dready}), W'(0));
        end
        mready = 1'b1;
        #1;
        check({tag, ".sbPop"}, W'(expQ.size() != 0), W'(1));
        if (expQ.size() != 0) begin
            h = expQ.pop_front();
            check({tag, ".iready"}, W'(iready), W'(!h.isData));
            check({tag, ".dready"}, W'(dready), W'(h.isData));
            if (!h.we) begin
                check({tag, ".rdata"}, h.isData ? drdata : irdata, memData(h.addr));
            end
        end
        cycle();
        mready = 1'b0;
        #1;
        check({tag, ".mreqDrop"}, W'(mreq), W'(0));
        check({tag, ".strobeDrop"}, W'({iready, dready}), W'(0));
    endtask

    initial begin
        int waited;
        int dIdx;
        bit expData;

        reset  = 1'b0;
        ireq   = 1'b0;
        iaddr  = '0;
        dreq   = 1'b0;
        dwe    = 1'b0;
        daddr  = '0;
        dwdata = '0;
        mready = 1'b0;
        repeat (2) cycle();

        // Reset state
        check("rst.mreq", W'(mreq), W'(0));
        check("rst.mwe", W'(mwe), W'(0));
        check("rst.maddr", maddr, W'(0));
        check("rst.mwdata", mwdata, W'(0));
        check("rst.err", W'(err), W'(0));
        check("rst.strobes", W'({iready, dready}), W'(0));
        reset = 1'b1;
        cycle();

        // Single fetch, mready in busy cycle 3
        ireq  = 1'b1;
        iaddr = 32'h0000_0040;
        push(1'b0, 1'b0, 32'h0000_0040, '0);
        #1;
        check("f1.idleNoReq", W'(mreq), W'(0));
        awaitGrant("f1", waited);
        check("f1.latency", W'(waited), W'(1));
        checkHead("f1");
        complete("f1", 3);
        ireq = 1'b0;

        // Simultaneous store and fetch: data wins, fetch granted at k+2
        ireq   = 1'b1;
        iaddr  = 32'h0000_0080;
        dreq   = 1'b1;
        dwe    = 1'b1;
        daddr  = 32'h0000_0100;
        dwdata = 32'hDEAD_BEEF;
        push(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        push(1'b0, 1'b0, 32'h0000_0080, '0);
        awaitGrant("st", waited);
        checkHead("st");
        complete("st", 2);
        dreq = 1'b0;
        dwe  = 1'b0;
        awaitGrant("f2", waited);
        check("f2.afterStore", W'(waited), W'(1));
        checkHead("f2");
        // Requester inputs changed mid-transaction must not reach the port
        iaddr = 32'h0000_0999;
        cycle();
        check("f2.addrHeld", maddr, 32'h0000_0080);
        complete("f2", 2);
        ireq = 1'b0;

        // Continuous loads with a waiting fetch
        ireq  = 1'b1;
        iaddr = 32'h0000_0200;
        dreq  = 1'b1;
        dIdx  = 0;
        daddr = 32'h0000_0300;
        for (int g = 1; g <= 6; g++) begin
            expData = GUARD ? (g != 5) : 1'b1;
            if (expData) begin
                push(1'b1, 1'b0, 32'h0000_0300 + 32'(dIdx * 4), '0);
            end else begin
                push(1'b0, 1'b0, 32'h0000_0200, '0);
            end
            awaitGrant($sformatf("sv%0d", g), waited);
            check($sformatf("sv%0d.latency", g), W'(waited), W'(1));
            checkHead($sformatf("sv%0d", g));
            complete($sformatf("sv%0d", g), 1);
            if (expData) begin
                dIdx++;
                daddr = 32'h0000_0300 + 32'(dIdx * 4);
            end else begin
                ireq = 1'b0;
            end
        end
        dreq = 1'b0;
        ireq = 1'b0;
        check("sv.errClear", W'(err), W'(0));
        cycle();

        // Watchdog: memory never acknowledges
        ireq  = 1'b1;
        iaddr = 32'h0000_0500;
        push(1'b0, 1'b0, 32'h0000_0500, '0);
        awaitGrant("wd", waited);
        checkHead("wd");
        repeat (255) cycle();
        check("wd.errAt256", W'(err), W'(0));
        cycle();
        check("wd.errAt257", W'(err), W'(1));
        check("wd.mreqStuck", W'(mreq), W'(1));
        check("wd.noStrobe", W'(iready), W'(0));
        repeat (3) cycle();
        check("wd.errSticky", W'(err), W'(1));
        reset = 1'b0;
        ireq  = 1'b0;
        #1;
        check("wd.rstErr", W'(err), W'(0));
        check("wd.rstMreq", W'(mreq), W'(0));
        check("wd.rstMaddr", maddr, W'(0));
        $display("txn wd: timeout observed, dropped by reset");
        expQ.delete();
        cycle();
        reset = 1'b1;
        cycle();

        // Reset mid-transaction, then normal service
        ireq  = 1'b1;
        iaddr = 32'h0000_0600;
        push(1'b0, 1'b0, 32'h0000_0600, '0);
        awaitGrant("mr", waited);
        checkHead("mr");
        cycle();
        reset  = 1'b0;
        mready = 1'b1;
        #1;
        check("mr.mreqAsync", W'(mreq), W'(0));
        check("mr.noStrobe", W'({iready, dready}), W'(0));
        check("mr.maddr", maddr, W'(0));
        $display("txn mr: dropped by reset");
        expQ.delete();
        ireq   = 1'b0;
        mready = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        ireq  = 1'b1;
        iaddr = 32'h0000_0640;
        push(1'b0, 1'b0, 32'h0000_0640, '0);
        awaitGrant("ar", waited);
        check("ar.latency", W'(waited), W'(1));
        checkHead("ar");
        complete("ar", 2);
        ireq = 1'b0;

        check("end.sbEmpty", W'(expQ.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
